// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
//
// Turns the byte stream from a UART receiver into validated command frames.
// Frame layout on the wire: SYNC_BYTE, LEN, LEN payload bytes, CSUM, where
// CSUM = LEN ^ payload[0] ^ ... ^ payload[LEN-1]. The payload is held in a
// local buffer and is only written to the downstream FIFO once the checksum
// matches, so a corrupted frame never leaks partial data downstream.
//
// Ports
//   clk         system clock
//   rst         asynchronous, active-low reset
//   b_tick      16x baud tick (one clk wide), reused for the inter-byte timeout
//   rx_data     received byte, valid while rx_done is high
//   rx_done     one-clk strobe, a byte has been received
//   fifo_full   downstream FIFO cannot accept a write
//   fifo_push   FIFO write strobe
//   fifo_wdata  payload byte written to the FIFO
//   frame_ok    one-clk pulse after the last byte of a frame has been pushed
//   frame_err   one-clk pulse when a frame is dropped or a byte is lost
//   err_code    cause of the latest error (0 length, 1 checksum, 2 timeout,
//               3 overrun); holds its value between errors
//   err_cnt     total error count, saturating at 255
//   ctrl_busy   high whenever the controller is not hunting for a sync byte
module uart_rx_frame_ctrl #(
  parameter logic [7:0] SYNC_BYTE     = 8'hAA,
  parameter int         MAX_LEN       = 16,
  parameter int         TIMEOUT_TICKS = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       b_tick,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       fifo_full,
  output logic       fifo_push,
  output logic [7:0] fifo_wdata,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic [7:0] err_cnt,
  output logic       ctrl_busy
);

  // IDX_W holds a length 0..MAX_LEN; PTR_W addresses the payload buffer.
  localparam int         IDX_W     = $clog2(MAX_LEN + 1);
  localparam int         PTR_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [15:0] TMO_LIM  = 16'(TIMEOUT_TICKS);

  localparam logic [1:0] E_LEN  = 2'd0;
  localparam logic [1:0] E_CSUM = 2'd1;
  localparam logic [1:0] E_TMO  = 2'd2;
  localparam logic [1:0] E_OVR  = 2'd3;

  typedef enum logic [2:0] {
    S_HUNT,
    S_LEN,
    S_PAYLOAD,
    S_CSUM,
    S_FLUSH
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] len_q;
  logic [7:0]       xor_q;
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] rd_idx;
  logic [15:0]      tmo_cnt;
  logic             tmo_hit;

  logic [7:0] buf_mem [MAX_LEN];

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  // True when idx addresses the final byte of a len-byte payload.
  function automatic logic is_last(input logic [PTR_W-1:0] idx,
                                   input logic [IDX_W-1:0] len);
    return (IDX_W'(idx) + IDX_W'(1)) == len;
  endfunction

  // A byte arriving in the same cycle always wins over the timeout.
  assign tmo_hit = ((state == S_LEN) || (state == S_PAYLOAD) || (state == S_CSUM)) &&
                   !rx_done && (tmo_cnt == TMO_LIM);

  assign fifo_push  = (state == S_FLUSH) && !fifo_full;
  assign fifo_wdata = (state == S_FLUSH) ? buf_mem[rd_idx] : 8'h00;
  assign ctrl_busy  = (state != S_HUNT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_HUNT;
      len_q     <= '0;
      xor_q     <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      tmo_cnt   <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= '0;
      err_cnt   <= '0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;

      // Inter-byte timer: restarts on every byte; states that do not time
      // out hold it at zero so each timed state is entered with a clean count.
      if (rx_done) begin
        tmo_cnt <= '0;
      end else if (b_tick) begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end

      case (state)
        S_HUNT: begin
          tmo_cnt <= '0;
          if (rx_done && (rx_data == SYNC_BYTE)) begin
            state <= S_LEN;
          end
        end

        S_LEN: begin
          if (rx_done) begin
            if ((rx_data == 8'h00) || (rx_data > MAX_LEN_B)) begin
              frame_err <= 1'b1;
              err_code  <= E_LEN;
              err_cnt   <= sat_inc(err_cnt);
              state     <= S_HUNT;
            end else begin
              len_q  <= rx_data[IDX_W-1:0];
              xor_q  <= rx_data;
              wr_idx <= '0;
              state  <= S_PAYLOAD;
            end
          end else if (tmo_hit) begin
            frame_err <= 1'b1;
            err_code  <= E_TMO;
            err_cnt   <= sat_inc(err_cnt);
            state     <= S_HUNT;
          end
        end

        S_PAYLOAD: begin
          if (rx_done) begin
            xor_q  <= xor_q ^ rx_data;
            wr_idx <= wr_idx + PTR_W'(1);
            if (is_last(wr_idx, len_q)) begin
              state <= S_CSUM;
            end
          end else if (tmo_hit) begin
            frame_err <= 1'b1;
            err_code  <= E_TMO;
            err_cnt   <= sat_inc(err_cnt);
            state     <= S_HUNT;
          end
        end

        S_CSUM: begin
          if (rx_done) begin
            if (rx_data == xor_q) begin
              rd_idx <= '0;
              state  <= S_FLUSH;
            end else begin
              frame_err <= 1'b1;
              err_code  <= E_CSUM;
              err_cnt   <= sat_inc(err_cnt);
              state     <= S_HUNT;
            end
          end else if (tmo_hit) begin
            frame_err <= 1'b1;
            err_code  <= E_TMO;
            err_cnt   <= sat_inc(err_cnt);
            state     <= S_HUNT;
          end
        end

        S_FLUSH: begin
          tmo_cnt <= '0;
          if (!fifo_full) begin
            rd_idx <= rd_idx + PTR_W'(1);
            if (is_last(rd_idx, len_q)) begin
              frame_ok <= 1'b1;
              state    <= S_HUNT;
            end
          end
          // A byte arriving while the buffer drains has nowhere to go.
          if (rx_done) begin
            frame_err <= 1'b1;
            err_code  <= E_OVR;
            err_cnt   <= sat_inc(err_cnt);
          end
        end

        default: state <= S_HUNT;
      endcase
    end
  end

  // Payload storage carries no reset; it is only read back in FLUSH after
  // every slot of the current frame has been written.
  always_ff @(posedge clk) begin
    if ((state == S_PAYLOAD) && rx_done) begin
      buf_mem[wr_idx] <= rx_data;
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
module tb_uart_rx_frame_ctrl;

  localparam int MAX_LEN = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       b_tick;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       fifo_full;
  logic       fifo_push;
  logic [7:0] fifo_wdata;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic [7:0] err_cnt;
  logic       ctrl_busy;

  uart_rx_frame_ctrl #(
    .SYNC_BYTE    (8'hAA),
    .MAX_LEN      (MAX_LEN),
    .TIMEOUT_TICKS(480)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .b_tick    (b_tick),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .fifo_full (fifo_full),
    .fifo_push (fifo_push),
    .fifo_wdata(fifo_wdata),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code),
    .err_cnt   (err_cnt),
    .ctrl_busy (ctrl_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Stimulus generator for b_tick and fifo_full.
  bit tick_en  = 1'b0;
  bit ff_rand  = 1'b0;
  bit ff_force = 1'b0;
  int cyc      = 0;

  always @(posedge clk) begin
    #1;
    b_tick    = tick_en && ((cyc % 2) == 0);
    fifo_full = ff_rand ? ($urandom_range(0, 2) == 0) : ff_force;
  end

  // Monitor: sampled on the falling edge.
  logic [7:0] push_q[$];
  int         push_cyc[$];
  int         ok_total    = 0;
  int         err_total   = 0;
  int         tick_total  = 0;
  int         tick_at_err = 0;
  int         full_viol   = 0;
  logic [1:0] last_code   = 2'd0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (fifo_push) begin
        push_q.push_back(fifo_wdata);
        push_cyc.push_back(cyc);
        if (fifo_full) full_viol++;
      end
      if (frame_ok) ok_total++;
      if (frame_err) begin
        err_total++;
        last_code   = err_code;
        tick_at_err = tick_total;
      end
      if (b_tick) tick_total++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: actual=%0d expected in [%0d,%0d]", nm, act, lo, hi);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge clk); #1;
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    repeat (gap) @(posedge clk);
  endtask

  task automatic wait_idle(input string nm, input int lim);
    int k;
    k = 0;
    while (ctrl_busy && k < lim) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk({nm, "_idle"}, ctrl_busy, 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  typedef struct {
    int               n;
    logic [0:7][7:0]  b;
    int               np;
    logic [0:3][7:0]  p;
    int               ok;
    int               err;
    logic [1:0]       code;
    logic [7:0]       cnt;
  } vec_t;

  vec_t vt[6];

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pb, ob, eb, t0, k;
    logic [7:0] exp_q[$];
    logic [7:0] tmp_q[$];
    int e_ok, e_err;
    logic [1:0] e_code;

    rst     = 1'b0;
    rx_done = 1'b0;
    rx_data = 8'h00;

    vt[0] = '{6, {8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03, 8'h00, 8'h00}, 3,
              {8'h11, 8'h22, 8'h33, 8'h00}, 1, 0, 2'd0, 8'd0};
    vt[1] = '{5, {8'hAA, 8'h02, 8'h10, 8'h20, 8'h31, 8'h00, 8'h00, 8'h00}, 0,
              {8'h00, 8'h00, 8'h00, 8'h00}, 0, 1, 2'd1, 8'd1};
    vt[2] = '{4, {8'hAA, 8'h01, 8'h5A, 8'h5B, 8'h00, 8'h00, 8'h00, 8'h00}, 1,
              {8'h5A, 8'h00, 8'h00, 8'h00}, 1, 0, 2'd1, 8'd1};
    vt[3] = '{2, {8'hAA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0,
              {8'h00, 8'h00, 8'h00, 8'h00}, 0, 1, 2'd0, 8'd2};
    vt[4] = '{2, {8'hAA, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0,
              {8'h00, 8'h00, 8'h00, 8'h00}, 0, 1, 2'd0, 8'd3};
    vt[5] = '{2, {8'h55, 8'h66, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0,
              {8'h00, 8'h00, 8'h00, 8'h00}, 0, 0, 2'd0, 8'd3};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", ctrl_busy, 0);
    chk("rst_push", fifo_push, 0);
    chk("rst_wdata", fifo_wdata, 0);
    chk("rst_ok", frame_ok, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_code", err_code, 0);
    chk("rst_cnt", err_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Table-driven frames
    for (int v = 0; v < 6; v++) begin
      pb = push_q.size();
      ob = ok_total;
      eb = err_total;
      for (int i = 0; i < vt[v].n; i++) send_byte(vt[v].b[i], 3);
      wait_idle($sformatf("v%0d", v), 200);
      chk($sformatf("v%0d_npush", v), push_q.size() - pb, vt[v].np);
      for (int i = 0; i < vt[v].np; i++)
        if (pb + i < push_q.size())
          chk($sformatf("v%0d_byte%0d", v, i), push_q[pb + i], vt[v].p[i]);
      if (vt[v].np > 1 && push_q.size() >= pb + vt[v].np)
        chk($sformatf("v%0d_back2back", v), push_cyc[pb + vt[v].np - 1] - push_cyc[pb],
            vt[v].np - 1);
      chk($sformatf("v%0d_ok", v), ok_total - ob, vt[v].ok);
      chk($sformatf("v%0d_errpulse", v), err_total - eb, vt[v].err);
      chk($sformatf("v%0d_errcnt", v), err_cnt, vt[v].cnt);
      if (vt[v].err > 0) chk($sformatf("v%0d_code", v), err_code, vt[v].code);
    end

    // Timeout after a stalled payload
    pb = push_q.size();
    ob = ok_total;
    eb = err_total;
    tick_en = 1'b1;
    send_byte(8'hAA, 3);
    send_byte(8'h04, 3);
    send_byte(8'h01, 3);
    send_byte(8'h02, 3);
    t0 = tick_total;
    k  = 0;
    while (err_total == eb && k < 1500) begin
      @(posedge clk);
      k++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("tmo_errpulse", err_total - eb, 1);
    chk_rng("tmo_ticks", tick_at_err - t0, 474, 482);
    chk("tmo_code", err_code, 2);
    chk("tmo_busy", ctrl_busy, 0);
    chk("tmo_npush", push_q.size() - pb, 0);
    chk("tmo_ok", ok_total - ob, 0);
    chk("tmo_errcnt", err_cnt, 4);

    // Slow bytes just inside the timeout keep the frame alive
    pb = push_q.size();
    ob = ok_total;
    eb = err_total;
    send_byte(8'hAA, 3);
    send_byte(8'h04, 800);
    send_byte(8'h01, 800);
    send_byte(8'h02, 800);
    send_byte(8'h03, 800);
    send_byte(8'h04, 800);
    send_byte(8'h00, 3);
    wait_idle("slow", 200);
    tick_en = 1'b0;
    chk("slow_npush", push_q.size() - pb, 4);
    for (int i = 0; i < 4; i++)
      if (pb + i < push_q.size()) chk($sformatf("slow_byte%0d", i), push_q[pb + i], i + 1);
    chk("slow_ok", ok_total - ob, 1);
    chk("slow_errpulse", err_total - eb, 0);

    // Backpressure with an overrun during the stall
    pb = push_q.size();
    ob = ok_total;
    eb = err_total;
    ff_force = 1'b1;
    send_byte(8'hAA, 3);
    send_byte(8'h02, 3);
    send_byte(8'hA1, 3);
    send_byte(8'hB2, 3);
    send_byte(8'h11, 3);
    repeat (20) @(posedge clk);
    #1;
    chk("bp_stall_npush", push_q.size() - pb, 0);
    chk("bp_stall_busy", ctrl_busy, 1);
    send_byte(8'h77, 2);
    #1;
    chk("ovr_errpulse", err_total - eb, 1);
    chk("ovr_code", err_code, 3);
    chk("ovr_busy", ctrl_busy, 1);
    chk("ovr_npush", push_q.size() - pb, 0);
    ff_force = 1'b0;
    wait_idle("bp", 100);
    chk("bp_npush", push_q.size() - pb, 2);
    if (push_q.size() >= pb + 2) begin
      chk("bp_byte0", push_q[pb], 8'hA1);
      chk("bp_byte1", push_q[pb + 1], 8'hB2);
    end
    chk("bp_ok", ok_total - ob, 1);
    chk("bp_errcnt", err_cnt, 5);

    // Asynchronous reset in the middle of a payload
    send_byte(8'hAA, 3);
    send_byte(8'h05, 3);
    send_byte(8'h01, 3);
    send_byte(8'h02, 1);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_busy", ctrl_busy, 0);
    chk("arst_cnt", err_cnt, 0);
    chk("arst_code", err_code, 0);
    chk("arst_ok", frame_ok, 0);
    chk("arst_err", frame_err, 0);
    chk("arst_push", fifo_push, 0);
    chk("arst_wdata", fifo_wdata, 0);
    @(negedge clk);
    rst = 1'b1;
    pb = push_q.size();
    ob = ok_total;
    eb = err_total;
    send_byte(8'hAA, 2);
    send_byte(8'h02, 2);
    send_byte(8'hC3, 2);
    send_byte(8'h3C, 2);
    send_byte(8'hFD, 2);
    wait_idle("post_rst", 100);
    chk("post_rst_npush", push_q.size() - pb, 2);
    if (push_q.size() >= pb + 2) begin
      chk("post_rst_byte0", push_q[pb], 8'hC3);
      chk("post_rst_byte1", push_q[pb + 1], 8'h3C);
    end
    chk("post_rst_ok", ok_total - ob, 1);
    chk("post_rst_errpulse", err_total - eb, 0);

    // Error counter saturation
    eb = err_total;
    for (int i = 0; i < 260; i++) begin
      send_byte(8'hAA, 1);
      send_byte(8'h00, 2);
      if (i == 253) begin
        #1;
        chk("sat_cnt254", err_cnt, 254);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    chk("sat_errpulse", err_total - eb, 260);
    chk("sat_cnt255", err_cnt, 255);

    // Randomized frames against the frame-level model
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    pb = push_q.size();
    ob = ok_total;
    eb = err_total;
    e_ok = 0;
    e_err = 0;
    e_code = 2'd0;
    ff_rand = 1'b1;
    for (int it = 0; it < 60; it++) begin
      int r, len, gap;
      logic [7:0] d, x;
      r = $urandom_range(0, 3);
      gap = $urandom_range(0, 4);
      case (r)
        0: begin
          d = 8'($urandom_range(0, 255));
          if (d == 8'hAA) d = 8'h55;
          send_byte(d, gap);
        end
        1, 2: begin
          len = $urandom_range(1, MAX_LEN);
          send_byte(8'hAA, gap);
          send_byte(8'(len), gap);
          x = 8'(len);
          tmp_q.delete();
          for (int i = 0; i < len; i++) begin
            d = 8'($urandom_range(0, 255));
            x ^= d;
            tmp_q.push_back(d);
            send_byte(d, $urandom_range(0, 4));
          end
          if (r == 1) begin
            send_byte(x, gap);
            foreach (tmp_q[i]) exp_q.push_back(tmp_q[i]);
            e_ok++;
          end else begin
            send_byte(x ^ 8'($urandom_range(1, 255)), gap);
            e_err++;
            e_code = 2'd1;
          end
        end
        default: begin
          len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_LEN + 1, 255);
          send_byte(8'hAA, gap);
          send_byte(8'(len), gap);
          e_err++;
          e_code = 2'd0;
        end
      endcase
      wait_idle($sformatf("rnd%0d", it), 400);
    end
    ff_rand = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rnd_npush", push_q.size() - pb, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (pb + i < push_q.size()) chk($sformatf("rnd_byte%0d", i), push_q[pb + i], exp_q[i]);
    chk("rnd_ok", ok_total - ob, e_ok);
    chk("rnd_errpulse", err_total - eb, e_err);
    chk("rnd_errcnt", err_cnt, (e_err > 255) ? 255 : e_err);
    if (e_err > 0) chk("rnd_code", err_code, e_code);
    chk("push_while_full", full_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
